// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port between NUM_REQ requesters, bursts of up to MAX_BURST.
// Latency : 1 cycle of arbitration from request to grant, then data passes through combinationally; 1 idle bubble after each grant.
// Backpress: elem_ready_i is routed only to the granted requester; a stalled FIFO holds the grant indefinitely.
//
// Ports:
//   clk_i, arst_ni        write-domain clock, async active-low reset
//   req_data_i/valid_i    packed requester data (k at [k*ELEM_WIDTH +: ELEM_WIDTH]) and valids
//   req_ready_o           per-requester ready, only the granted bit can be set
//   elem_o/valid_o/ready_i  FIFO write port
//   grant_o, grant_idx_o  one-hot grant (zero when idle) and current/last granted index
//   busy_o                high while a grant is held
//   prio_i                only with FIFO_WR_ARB_PRIO_EN defined: requester 0 wins in IDLE, pointer untouched
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ*ELEM_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [ELEM_WIDTH-1:0]         elem_o,
    output logic                          elem_valid_o,
    input  logic                          elem_ready_i,
`ifdef FIFO_WR_ARB_PRIO_EN
    input  logic                          prio_i,
`endif
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t             r_state,     w_state_nxt;
    logic [IDX_W-1:0]   r_g,         w_g_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,    w_rr_nxt;
    logic [CNT_W-1:0]   r_burst_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
    logic               r_prio,      w_prio_nxt;

    logic [ELEM_WIDTH-1:0] w_req_data [NUM_REQ];
    logic [IDX_W-1:0]      w_cand;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_found;
    logic                  w_hs;
    logic                  w_prio_take;

    // Unpacked view of the flat data bus so the mux indexes by grant directly.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_req_data[k] = req_data_i[k*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

    // First valid requester scanning from the round-robin pointer with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

`ifdef FIFO_WR_ARB_PRIO_EN
    assign w_prio_take = prio_i & req_valid_i[0];
`else
    assign w_prio_take = 1'b0;
`endif

    // Write-port path: only live while a grant is held.
    always_comb begin
        elem_o       = '0;
        elem_valid_o = 1'b0;
        req_ready_o  = '0;
        if (r_state == ST_GRANT) begin
            elem_o           = w_req_data[r_g];
            elem_valid_o     = req_valid_i[r_g];
            req_ready_o[r_g] = elem_ready_i;
        end
    end

    assign w_hs = elem_valid_o & elem_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_burst_cnt;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_cnt_nxt   = '0;
                    if (w_prio_take) begin
                        w_g_nxt    = '0;
                        w_prio_nxt = 1'b1;
                    end else begin
                        w_g_nxt    = w_pick;
                        w_prio_nxt = 1'b0;
                    end
                    w_grant_nxt = NUM_REQ'(1) << w_g_nxt;
                end
            end
            ST_GRANT: begin
                // Burst limit reached or requester withdrew: release and leave one bubble.
                if ((w_hs && (r_burst_cnt == CNT_W'(MAX_BURST - 1))) || !req_valid_i[r_g]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    // A priority grant must not disturb the round-robin order.
                    if (!r_prio) begin
                        w_rr_nxt = (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
                    end
                end else if (w_hs) begin
                    w_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state     <= ST_IDLE;
            r_g         <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_grant     <= '0;
            r_prio      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_g         <= w_g_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_prio      <= w_prio_nxt;
        end
    end

    assign grant_o     = r_grant;
    assign grant_idx_o = r_g;
    assign busy_o      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : self-checking bench for fifo_wr_arbiter (NUM_REQ=4, ELEM_WIDTH=8, MAX_BURST=4).
// Latency : requester models drive at #1 after posedge; handshakes sampled on the negedge.
// Backpress: elem_ready is bench-controlled to create FIFO-full stalls.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [W-1:0]    elem;
    logic            elem_valid;
    logic            elem_ready;
    logic [NR-1:0]   grant;
    logic [1:0]      grant_idx;
    logic            busy;
`ifdef FIFO_WR_ARB_PRIO_EN
    logic            prio;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .ELEM_WIDTH(W), .MAX_BURST(4)) u_dut (
        .clk_i        (clk),
        .arst_ni      (arst_n),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .elem_o       (elem),
        .elem_valid_o (elem_valid),
        .elem_ready_i (elem_ready),
`ifdef FIFO_WR_ARB_PRIO_EN
        .prio_i       (prio),
`endif
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] src_q [NR][$];
    int         stamp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() > 0) begin
                req_data[k*W +: W] = src_q[k][0];
                req_valid[k]       = 1'b1;
            end else begin
                req_data[k*W +: W] = '0;
                req_valid[k]       = 1'b0;
            end
        end
    endtask

    // Load n elements base, base+1, ... into requester k and expect them on the FIFO side.
    task automatic load(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src_q[k].push_back(base + 8'(i));
    endtask

    task automatic expect_elems(input int k, input logic [7:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx = 2'(k);
            e.dat = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    // One clock: check a handshake on the negedge, retire it at the posedge, redrive at +1.
    task automatic step();
        int   hk;
        exp_t e;
        hk = -1;
        @(negedge clk);
        if (elem_valid && elem_ready) begin
            for (int k = 0; k < NR; k++) if (req_ready[k]) hk = k;
            stamp_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_hs", 32'(hk), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("hs_idx", 32'(hk), 32'(e.idx));
                chk("hs_dat", 32'(elem), 32'(e.dat));
            end
        end
        @(posedge clk);
        #1;
        if (hk >= 0) void'(src_q[hk].pop_front());
        cyc++;
        drive();
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > target && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(target));
    endtask

    task automatic settle();
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        arst_n     = 1'b0;
        elem_ready = 1'b1;
        req_data   = '0;
        req_valid  = '0;
`ifdef FIFO_WR_ARB_PRIO_EN
        prio       = 1'b0;
`endif
        // Reset held with every requester valid.
        for (int k = 0; k < NR; k++) begin
            load(k, 8'h10 + 8'(k), 1);
            expect_elems(k, 8'h10 + 8'(k), 1);
        end
        drive();
        repeat (3) step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(elem_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_elem", 32'(elem), 32'd0);
        arst_n = 1'b1;
        #1;
        chk("rel_grant0", 32'(grant), 32'd0);
        step();
        chk("grant_after_rst", 32'(grant), 32'b0001);
        run_until(0, 40);
        settle();

        // Burst limit: requesters 0 and 2 streaming, ready always high.
        stamp_q.delete();
        load(0, 8'hA0, 8);
        load(2, 8'hC0, 8);
        expect_elems(0, 8'hA0, 4);
        expect_elems(2, 8'hC0, 4);
        expect_elems(0, 8'hA4, 4);
        expect_elems(2, 8'hC4, 4);
        drive();
        run_until(0, 60);
        chk("burst_hs_cnt", 32'(stamp_q.size()), 32'd16);
        for (int i = 0; i < 15 && i + 1 < stamp_q.size(); i++) begin
            chk("burst_gap", 32'(stamp_q[i+1] - stamp_q[i]), (i % 4 == 3) ? 32'd2 : 32'd1);
        end
        settle();

        // Early release by requester 1, then pointer goes to 3, then wraps to 0.
        load(1, 8'hB0, 2);
        drive();
        step();
        load(3, 8'hD0, 5);
        load(0, 8'hE0, 1);
        drive();
        expect_elems(1, 8'hB0, 2);
        expect_elems(3, 8'hD0, 4);
        expect_elems(0, 8'hE0, 1);
        expect_elems(3, 8'hD4, 1);
        run_until(0, 60);
        settle();

        // FIFO-full stall mid-burst; burst length must survive the stall.
        load(2, 8'hF0, 5);
        load(3, 8'h50, 1);
        drive();
        expect_elems(2, 8'hF0, 4);
        expect_elems(3, 8'h50, 1);
        expect_elems(2, 8'hF4, 1);
        run_until(5, 20);
        elem_ready = 1'b0;
        repeat (10) begin
            step();
            chk("stall_grant", 32'(grant), 32'b0100);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_elem", 32'(elem), 32'hF1);
            chk("stall_valid", 32'(elem_valid), 32'd1);
        end
        elem_ready = 1'b1;
        run_until(0, 40);
        settle();

        // Reset mid-burst: grant drops at once, in-flight element stays with requester 1.
        load(1, 8'h60, 4);
        drive();
        expect_elems(1, 8'h60, 2);
        run_until(0, 20);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_valid", 32'(elem_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        chk("mid_rst_kept", 32'(src_q[1].size()), 32'd2);
        chk("mid_rst_front", 32'(src_q[1][0]), 32'h62);
        arst_n = 1'b1;
        expect_elems(1, 8'h62, 2);
        run_until(0, 20);
        settle();

`ifdef FIFO_WR_ARB_PRIO_EN
        // Pointer sits at 2; priority grant to 0 must leave it there.
        prio = 1'b1;
        load(0, 8'h70, 1);
        load(1, 8'h80, 1);
        load(2, 8'h90, 1);
        drive();
        expect_elems(0, 8'h70, 1);
        expect_elems(2, 8'h90, 1);
        expect_elems(1, 8'h80, 1);
        run_until(0, 40);
        prio = 1'b0;
        settle();
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
